// File: rtl/mul_arbiter.sv
// Round-robin front end that lets N clients share one multiplier: grant, issue,
// wait for done (with a timeout guard), then hand the result back with an ack.
module mul_arbiter #(
    parameter int N       = 4,
    parameter int W       = 32,
    parameter int TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] op1_in,
    input  logic [N*W-1:0] op2_in,
    output logic [N-1:0]   ack,
    output logic [W-1:0]   res,
    output logic           err,
    output logic           busy,
    output logic           mul_ready,
    output logic [W-1:0]   mul_op1,
    output logic [W-1:0]   mul_op2,
    input  logic [W-1:0]   mul_res,
    input  logic           mul_done,
    output logic [1:0]     dbg_state
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    // Handshakes: req is a level held until its ack; ack is a one-cycle pulse
    // qualifying res/err; mul_ready is a one-cycle start and mul_done is a
    // completion strobe that only counts while in WAIT.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RET   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   g_q, g_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N-1:0]    ack_q, ack_d;
    logic [W-1:0]    res_q, res_d;
    logic            err_q, err_d;
    logic            busy_q, busy_d;
    logic            mul_ready_q, mul_ready_d;
    logic [W-1:0]    op1_q, op1_d;
    logic [W-1:0]    op2_q, op2_d;

    logic [W-1:0]    op1_arr [N];
    logic [W-1:0]    op2_arr [N];
    logic            gnt_vld;
    logic [PW-1:0]   gnt_idx;

    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign op1_arr[i] = op1_in[i*W +: W];
        assign op2_arr[i] = op2_in[i*W +: W];
    end

    // Scan starts just after the last winner so every requester gets a turn.
    always_comb begin
        int          idx;
        logic [PW-1:0] idx_w;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        idx_w   = '0;
        for (int k = 1; k <= N; k++) begin
            idx   = (int'(ptr_q) + k) % N;
            idx_w = PW'(idx);
            if (!gnt_vld && req[idx_w]) begin
                gnt_vld = 1'b1;
                gnt_idx = idx_w;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        g_d         = g_q;
        cnt_d       = cnt_q;
        ack_d       = '0;
        res_d       = res_q;
        err_d       = err_q;
        busy_d      = busy_q;
        mul_ready_d = 1'b0;
        op1_d       = op1_q;
        op2_d       = op2_q;
        case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    g_d         = gnt_idx;
                    ptr_d       = gnt_idx;
                    op1_d       = op1_arr[gnt_idx];
                    op2_d       = op2_arr[gnt_idx];
                    mul_ready_d = 1'b1;
                    busy_d      = 1'b1;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + CW'(1);
                // A done arriving on the last counted cycle still wins over the timeout.
                if (mul_done) begin
                    res_d       = mul_res;
                    err_d       = 1'b0;
                    ack_d[g_q]  = 1'b1;
                    state_d     = RET;
                end else if (cnt_q == CNT_LAST) begin
                    res_d       = '0;
                    err_d       = 1'b1;
                    ack_d[g_q]  = 1'b1;
                    state_d     = RET;
                end
            end
            RET: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            ptr_q       <= PW'(N - 1);
            g_q         <= '0;
            cnt_q       <= '0;
            ack_q       <= '0;
            res_q       <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            mul_ready_q <= 1'b0;
            op1_q       <= '0;
            op2_q       <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            g_q         <= g_d;
            cnt_q       <= cnt_d;
            ack_q       <= ack_d;
            res_q       <= res_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            mul_ready_q <= mul_ready_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
        end
    end

    assign ack       = ack_q;
    assign res       = res_q;
    assign err       = err_q;
    assign busy      = busy_q;
    assign mul_ready = mul_ready_q;
    assign mul_op1   = op1_q;
    assign mul_op2   = op2_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mul_arbiter.sv
// Bench for mul_arbiter: transaction-level reference model with a timing
// scoreboard, a behavioural multiplier, directed phases and random traffic.
module tb_mul_arbiter;
  localparam int N = 4;
  localparam int W = 32;
  localparam int TIMEOUT = 64;
  localparam int EW = N + 1 + W;

  logic clk;
  logic rst;
  logic [N-1:0] req;
  logic [N*W-1:0] op1_in, op2_in;
  logic [N-1:0] ack;
  logic [W-1:0] res;
  logic err, busy, mul_ready;
  logic [W-1:0] mul_op1, mul_op2, mul_res;
  logic mul_done;
  logic [1:0] dbg_state;

  mul_arbiter #(.N(N), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .op1_in(op1_in), .op2_in(op2_in),
    .ack(ack), .res(res), .err(err), .busy(busy), .mul_ready(mul_ready),
    .mul_op1(mul_op1), .mul_op2(mul_op2), .mul_res(mul_res),
    .mul_done(mul_done), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int lat_mode = 0;
  logic spur = 1'b0;
  logic rand_en = 1'b0;
  logic [N-1:0] sticky = '0;
  int unsigned a_int [N];
  int unsigned b_int [N];

  logic [EW-1:0] exp_q[$];
  int exp_cyc_q[$];
  logic [2*W-1:0] op_q[$];
  int op_cyc_q[$];
  logic [N-1:0] ack_log[$];
  int busy_from = 1;
  int busy_to = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] i2f(input int unsigned x);
    int e;
    logic [31:0] m;
    if (x == 0) return 32'd0;
    e = 0;
    for (int i = 0; i < 32; i++) if (((x >> i) & 1) != 0) e = i;
    if (e <= 23) m = x << (23 - e);
    else m = x >> (e - 23);
    return {1'b0, 8'(127 + e), m[22:0]};
  endfunction

  function automatic int unsigned f2i(input logic [31:0] f);
    int e;
    logic [31:0] m;
    if (f[30:23] == 8'd0) return 0;
    e = int'(f[30:23]) - 127;
    m = {8'd0, 1'b1, f[22:0]};
    if (e <= 23) return m >> (23 - e);
    return m << (e - 23);
  endfunction

  function automatic int lat_of(input logic [31:0] a, input logic [31:0] b);
    if (lat_mode != 0) return lat_mode;
    return int'(((a ^ b) >> 18) & 32'h7) + 1;
  endfunction

  function automatic logic bit_of(input logic [N-1:0] v, input int j);
    return ((v >> j) & N'(1)) != '0;
  endfunction

  // ---------------- behavioural multiplier ----------------
  initial begin
    int mcnt;
    logic [31:0] ma, mb;
    mcnt = 0;
    ma = '0;
    mb = '0;
    mul_done = 1'b0;
    mul_res = '0;
    forever begin
      @(negedge clk);
      mul_done = 1'b0;
      if (!rst) begin
        mcnt = 0;
        mul_res = '0;
      end else begin
        if (spur) begin
          mul_done = 1'b1;
          mul_res = 32'hDEAD_BEEF;
        end
        if (mcnt > 0) begin
          mcnt--;
          if (mcnt == 0) begin
            mul_done = 1'b1;
            mul_res = i2f(f2i(ma) * f2i(mb));
          end
        end
        if (mul_ready) begin
          mcnt = lat_of(mul_op1, mul_op2);
          ma = mul_op1;
          mb = mul_op2;
        end
      end
    end
  end

  // ---------------- reference model (transaction level) ----------------
  initial begin
    int ptr_m, free_m, g, j, lat, ack_c;
    logic [W-1:0] a, b;
    logic [N-1:0] oh;
    ptr_m = N - 1;
    free_m = 0;
    forever begin
      @(posedge clk);
      if (!rst) begin
        ptr_m = N - 1;
        free_m = 0;
        exp_q.delete();
        exp_cyc_q.delete();
        op_q.delete();
        op_cyc_q.delete();
        busy_from = 1;
        busy_to = 0;
      end else if (cyc >= free_m && req != '0) begin
        g = -1;
        for (int k = 1; k <= N; k++) begin
          j = (ptr_m + k) % N;
          if (g < 0 && bit_of(req, j)) g = j;
        end
        a = W'(op1_in >> (g * W));
        b = W'(op2_in >> (g * W));
        oh = N'(1) << g;
        lat = lat_of(a, b);
        if (lat <= TIMEOUT) begin
          ack_c = cyc + lat + 2;
          exp_q.push_back({oh, 1'b0, i2f(a_int[g] * b_int[g])});
        end else begin
          ack_c = cyc + TIMEOUT + 2;
          exp_q.push_back({oh, 1'b1, {W{1'b0}}});
        end
        exp_cyc_q.push_back(ack_c);
        op_q.push_back({a, b});
        op_cyc_q.push_back(cyc + 1);
        busy_from = cyc + 1;
        busy_to = ack_c;
        free_m = ack_c + 1;
        ptr_m = g;
      end
      cyc = cyc + 1;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic prev_mr;
    logic [EW-1:0] e;
    logic [2*W-1:0] o;
    int c;
    prev_mr = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("reset_outputs", {ack, res, err, busy, mul_ready, mul_op1, mul_op2}, '0);
        prev_mr = 1'b0;
      end else begin
        if (ack != '0) begin
          ack_log.push_back(ack);
          if (exp_q.size() == 0) begin
            chk("unexpected_ack", ack, '0);
          end else begin
            e = exp_q.pop_front();
            c = exp_cyc_q.pop_front();
            chk("ack_res_err", {ack, err, res}, e);
            chk("ack_cycle", cyc, c);
          end
        end else if (exp_cyc_q.size() > 0 && cyc > exp_cyc_q[0]) begin
          chk("ack_missing", cyc, exp_cyc_q[0]);
          void'(exp_q.pop_front());
          void'(exp_cyc_q.pop_front());
        end
        chk("ack_onehot", $onehot0(ack), 1);
        chk("busy", busy, (cyc >= busy_from && cyc <= busy_to));
        if (mul_ready) begin
          chk("mul_ready_single", prev_mr, 0);
          if (op_q.size() == 0) begin
            chk("unexpected_mul_ready", mul_ready, 0);
          end else begin
            o = op_q.pop_front();
            c = op_cyc_q.pop_front();
            chk("mul_operands", {mul_op1, mul_op2}, o);
            chk("mul_ready_cycle", cyc, c);
          end
        end
        prev_mr = mul_ready;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input int i, input int unsigned a, input int unsigned b);
    logic [N*W-1:0] mask;
    mask = {{(N*W-W){1'b0}}, {W{1'b1}}} << (i * W);
    a_int[i] = a;
    b_int[i] = b;
    op1_in = (op1_in & ~mask) | ((N*W)'(i2f(a)) << (i * W));
    op2_in = (op2_in & ~mask) | ((N*W)'(i2f(b)) << (i * W));
    req = req | (N'(1) << i);
  endtask

  task automatic step();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (bit_of(ack, i) && !bit_of(sticky, i)) req = req & ~(N'(1) << i);
      else if (rand_en && !bit_of(req, i) && !bit_of(ack, i) && $urandom_range(0, 5) == 0)
        set_req(i, $urandom_range(1, 4000), $urandom_range(1, 4000));
    end
  endtask

  task automatic drain(input int limit);
    int k;
    k = 0;
    while ((req != '0 || busy || exp_q.size() != 0) && k < limit) begin
      step();
      k++;
    end
    chk("drain_in_budget", k < limit, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    req = '0;
    repeat (2) step();
    rst = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    rst = 1'b0;
    req = '0;
    op1_in = '0;
    op2_in = '0;
    repeat (3) step();
    rst = 1'b1;

    // single request, latency 5: 2.0 * 3.0
    lat_mode = 5;
    base = ack_log.size();
    set_req(0, 2, 3);
    drain(100);
    chk("single_ack_count", ack_log.size() - base, 1);
    chk("single_who", ack_log[base], 4'b0001);
    chk("single_res", res, 32'h40C0_0000);
    chk("single_err", err, 0);

    // simultaneous requests straight out of reset
    do_reset();
    lat_mode = 0;
    base = ack_log.size();
    set_req(0, 3, 2);
    set_req(1, 5, 7);
    set_req(2, 11, 13);
    set_req(3, 100, 250);
    drain(200);
    chk("simul_ack_count", ack_log.size() - base, 4);
    for (int i = 0; i < 4; i++) chk("simul_order", ack_log[base + i], N'(1) << i);

    // fairness: 0 held continuously, 2 raised during 0's WAIT
    lat_mode = 6;
    sticky = 4'b0101;
    base = ack_log.size();
    set_req(0, 9, 9);
    repeat (4) step();
    set_req(2, 12, 12);
    for (int k = 0; k < 400 && (ack_log.size() - base) < 8; k++) begin
      step();
      if ((ack_log.size() - base) >= 8) begin
        sticky = '0;
        req = '0;
      end
    end
    sticky = '0;
    req = '0;
    drain(100);
    chk("fair_ack_count", ack_log.size() - base, 8);
    for (int k = 0; k < 8; k++)
      chk("fair_alternate", ack_log[base + k], (k % 2 == 0) ? 4'b0001 : 4'b0100);

    // timeout, then a normal request
    lat_mode = 1000;
    set_req(1, 7, 9);
    drain(200);
    chk("timeout_ack", ack_log[ack_log.size() - 1], 4'b0010);
    chk("timeout_err", err, 1);
    chk("timeout_res", res, 0);
    lat_mode = 3;
    set_req(1, 4, 5);
    drain(100);
    chk("after_timeout_err", err, 0);
    chk("after_timeout_res", res, 32'h41A0_0000);

    // done on the last counted cycle wins; one cycle later is a timeout
    lat_mode = TIMEOUT;
    set_req(3, 6, 9);
    drain(200);
    chk("edge_done_err", err, 0);
    chk("edge_done_res", res, 32'h4258_0000);
    lat_mode = TIMEOUT + 1;
    set_req(3, 6, 9);
    drain(200);
    chk("edge_late_err", err, 1);
    chk("edge_late_res", res, 0);

    // spurious done while idle
    lat_mode = 0;
    repeat (3) step();
    base = ack_log.size();
    spur = 1'b1;
    repeat (2) step();
    spur = 1'b0;
    repeat (5) step();
    chk("spurious_no_ack", ack_log.size() - base, 0);

    // random traffic
    rand_en = 1'b1;
    repeat (400) step();
    rand_en = 1'b0;
    drain(600);

    // reset while waiting on the multiplier
    lat_mode = 20;
    set_req(0, 2, 2);
    set_req(1, 3, 3);
    set_req(2, 4, 4);
    set_req(3, 5, 5);
    repeat (4) step();
    base = ack_log.size();
    #2 rst = 1'b0;
    #1;
    chk("rst_async_outs", {ack, res, err, busy, mul_ready, mul_op1, mul_op2}, '0);
    req = '0;
    repeat (2) step();
    rst = 1'b1;
    chk("rst_no_ack", ack_log.size() - base, 0);
    lat_mode = 2;
    set_req(0, 8, 8);
    set_req(1, 3, 6);
    set_req(2, 10, 10);
    set_req(3, 1, 1);
    drain(200);
    chk("rst_first_grant", ack_log[base], 4'b0001);
    chk("rst_ack_count", ack_log.size() - base, 4);

    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
